// File: rtl/mmp_iddmm_ctrl.sv
// Sequencer for an iterative-digit Montgomery multiplier (IDDMM).
// Clears the accumulator RAM, issues the N x (N+1) PE word schedule,
// writes PE results back after the pipeline latency, stores the final
// carry word, then streams a final a - m subtraction to select the result.
module mmp_iddmm_ctrl #(
  parameter  int K       = 128,
  parameter  int N       = 32,
  parameter  int LATENCY = 16,
  localparam int IW      = $clog2(N),
  localparam int JW      = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] i,
  output logic [JW-1:0] j,
  output logic          ctl_carry_clr,
  output logic          ctl_carry_ena,
  output logic          ctl_carry_sel,
  output logic          ctl_c_pre_clr,
  output logic          ctl_q_ena,
  input  logic          carry,
  input  logic [K-1:0]  uj,
  output logic [JW-1:0] rd_addr,
  input  logic [K-1:0]  rd_data,
  input  logic [K-1:0]  m_word,
  output logic          wr_ena,
  output logic [JW-1:0] wr_addr,
  output logic [K-1:0]  wr_data,
  output logic          res_valid,
  output logic [K-1:0]  res_a,
  output logic [K-1:0]  res_d,
  output logic          res_last,
  output logic          res_sel
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_CARRY,
    S_SUB,
    S_DONE
  } state_t;

  // Word index N is the top (carry) word of the a-RAM and the last column of a line.
  localparam logic [JW-1:0] LAST_J     = JW'(N);
  localparam logic [IW-1:0] LAST_I     = IW'(N - 1);
  localparam logic [JW-1:0] LAST_DRAIN = JW'(LATENCY - 1);

  state_t                       state_q, state_d;
  logic [IW-1:0]                i_q, i_d;
  logic [JW-1:0]                j_q, j_d;
  logic [JW-1:0]                cnt_q, cnt_d;
  logic                         b_q, b_d;
  logic                         sel_q, sel_d;
  logic [LATENCY-1:0]           dv_q, dv_d;
  logic [LATENCY-1:0][JW-1:0]   dj_q, dj_d;

  logic                         b_in;
  logic [K:0]                   diff;
  logic                         b_out;
  logic                         wb_valid;
  logic [JW-1:0]                wb_j;

  // Subtract one word of m (plus the borrow from the previous word) from the a word.
  always_comb begin
    b_in  = (cnt_q == '0) ? 1'b0 : b_q;
    diff  = {1'b0, rd_data} - {1'b0, m_word} - {{K{1'b0}}, b_in};
    b_out = diff[K];
  end

  // Next-state logic for the phase sequencer and its counters.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          sel_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == LAST_J) begin
          state_d = S_RUN;
          cnt_d   = '0;
          i_d     = '0;
          j_d     = '0;
        end else begin
          cnt_d = cnt_q + JW'(1);
        end
      end
      S_RUN: begin
        if (j_q == LAST_J) begin
          j_d = '0;
          if (i_q == LAST_I) begin
            state_d = S_DRAIN;
            i_d     = '0;
            cnt_d   = '0;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == LAST_DRAIN) begin
          state_d = S_CARRY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + JW'(1);
        end
      end
      S_CARRY: begin
        state_d = S_SUB;
        cnt_d   = '0;
        b_d     = 1'b0;
      end
      S_SUB: begin
        b_d = b_out;
        if (cnt_q == LAST_J) begin
          state_d = S_DONE;
          sel_d   = ~b_out;
          cnt_d   = '0;
          b_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + JW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Issue delay line: each RUN cycle's column index follows the PE pipeline.
  always_comb begin
    dv_d    = dv_q;
    dj_d    = dj_q;
    dv_d[0] = (state_q == S_RUN);
    dj_d[0] = j_q;
    for (int s = 1; s < LATENCY; s++) begin
      dv_d[s] = dv_q[s-1];
      dj_d[s] = dj_q[s-1];
    end
  end

  // State register with synchronous reset; reset also flushes in-flight issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      b_q     <= 1'b0;
      sel_q   <= 1'b0;
      dv_q    <= '0;
      dj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      dv_q    <= dv_d;
      dj_q    <= dj_d;
    end
  end

  assign wb_valid = dv_q[LATENCY-1];
  assign wb_j     = dj_q[LATENCY-1];
  assign i        = i_q;
  assign j        = j_q;
  assign res_sel  = sel_q;

  // Output decode; the phases never overlap, so at most one write source is active.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    ctl_carry_clr = 1'b0;
    ctl_carry_ena = 1'b0;
    ctl_carry_sel = 1'b0;
    ctl_c_pre_clr = 1'b0;
    ctl_q_ena     = 1'b0;
    rd_addr       = '0;
    wr_ena        = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    res_valid     = 1'b0;
    res_a         = '0;
    res_d         = '0;
    res_last      = 1'b0;
    case (state_q)
      S_CLEAR: begin
        busy    = 1'b1;
        wr_ena  = 1'b1;
        wr_addr = cnt_q;
      end
      S_RUN: begin
        busy          = 1'b1;
        rd_addr       = j_q;
        ctl_carry_clr = (i_q == '0) && (j_q == '0);
        ctl_carry_ena = (j_q == LAST_J);
        ctl_carry_sel = (j_q == LAST_J);
        ctl_c_pre_clr = (j_q == '0);
        ctl_q_ena     = (j_q == '0);
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      S_CARRY: begin
        busy    = 1'b1;
        wr_ena  = 1'b1;
        wr_addr = LAST_J;
        wr_data = {{(K-1){1'b0}}, carry};
      end
      S_SUB: begin
        busy      = 1'b1;
        rd_addr   = cnt_q;
        res_valid = 1'b1;
        res_a     = rd_data;
        res_d     = diff[K-1:0];
        res_last  = (cnt_q == LAST_J);
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    if (wb_valid && (wb_j != '0)) begin
      wr_ena  = 1'b1;
      wr_addr = wb_j - JW'(1);
      wr_data = uj;
    end
  end

endmodule

// File: tb/tb_mmp_iddmm_ctrl.sv
// Bench for the IDDMM sequencer with K=8, N=4, LATENCY=3: a behavioural
// a-RAM and PE stand-in, a cycle schedule derived from the phase lengths,
// and a big-integer model of the final subtraction.
module tb_mmp_iddmm_ctrl;

  localparam int K   = 8;
  localparam int N   = 4;
  localparam int LAT = 3;

  localparam int CLR0 = 1;
  localparam int RUN0 = CLR0 + N + 1;
  localparam int DRN0 = RUN0 + N * (N + 1);
  localparam int CAR  = DRN0 + LAT;
  localparam int SUB0 = CAR + 1;
  localparam int DONE = SUB0 + N + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         busy, done;
  logic [1:0]   i;
  logic [2:0]   j;
  logic         ctlCarryClr, ctlCarryEna, ctlCarrySel, ctlCPreClr, ctlQEna;
  logic         carry = 1'b0;
  logic [7:0]   uj = 8'h00;
  logic [2:0]   rdAddr;
  logic [7:0]   rdData, mWord;
  logic         wrEna;
  logic [2:0]   wrAddr;
  logic [7:0]   wrData;
  logic         resValid, resLast, resSel;
  logic [7:0]   resA, resD;

  logic [7:0]   ram  [0:N];
  logic [7:0]   mMem [0:N-1];

  int total = 0;
  int bad   = 0;
  int curCycle = 0;

  mmp_iddmm_ctrl #(.K(K), .N(N), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .i(i), .j(j),
    .ctl_carry_clr(ctlCarryClr), .ctl_carry_ena(ctlCarryEna),
    .ctl_carry_sel(ctlCarrySel), .ctl_c_pre_clr(ctlCPreClr), .ctl_q_ena(ctlQEna),
    .carry(carry), .uj(uj),
    .rd_addr(rdAddr), .rd_data(rdData), .m_word(mWord),
    .wr_ena(wrEna), .wr_addr(wrAddr), .wr_data(wrData),
    .res_valid(resValid), .res_a(resA), .res_d(resD),
    .res_last(resLast), .res_sel(resSel)
  );

  always #5 clk = ~clk;

  // Behavioural a-RAM: synchronous write, combinational read.
  always @(posedge clk) begin
    if (wrEna && (wrAddr <= 3'(N))) ram[wrAddr] <= wrData;
  end

  assign rdData = (rdAddr <= 3'(N)) ? ram[rdAddr] : 8'h00;
  assign mWord  = (rdAddr <  3'(N)) ? mMem[rdAddr[1:0]] : 8'h00;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, curCycle, act, exp);
    end
  endtask

  // Idle-state expectations used after reset.
  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"},   64'(busy), 64'd0);
    checkOutput({tag, "_done"},   64'(done), 64'd0);
    checkOutput({tag, "_wrEna"},  64'(wrEna), 64'd0);
    checkOutput({tag, "_i"},      64'(i), 64'd0);
    checkOutput({tag, "_j"},      64'(j), 64'd0);
    checkOutput({tag, "_resSel"}, 64'(resSel), 64'd0);
    checkOutput({tag, "_resVal"}, 64'(resValid), 64'd0);
    checkOutput({tag, "_ctlQ"},   64'(ctlQEna), 64'd0);
  endtask

  // One multiply, checked every cycle against the schedule and the subtraction model.
  task automatic applyStimulus(input logic [31:0] aw, input logic [31:0] mw, input logic carryBit,
                               input logic rnd, input int abortAt, input int startAt,
                               output logic selOut, output logic [7:0] d0Out);
    logic [7:0]  expMem [0:N];
    logic [63:0] aVal, mVal, dVal;
    logic        expSel;
    logic        wrE;
    logic [2:0]  wrA;
    logic [7:0]  wrD;
    int          idx, ic, wa, k;
    logic        inRun, inSub;
    selOut = 1'b0;
    d0Out  = 8'h00;
    expSel = 1'b0;
    aVal = '0; mVal = '0; dVal = '0;
    for (int n = 0; n <= N; n++) expMem[n] = 8'h00;
    for (int n = 0; n < N; n++) mMem[n] = mw[8*n +: 8];
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= DONE + 5; c++) begin
      curCycle = c;
      inRun = (c >= RUN0) && (c < DRN0);
      inSub = (c >= SUB0) && (c < DONE);
      idx   = c - RUN0;
      k     = c - SUB0;
      ic    = c - LAT;
      wrE = 1'b0; wrA = 3'd0; wrD = 8'h00;
      uj    = 8'($urandom);
      carry = 1'($urandom);
      if (c >= CLR0 && c < RUN0) begin
        wrE = 1'b1; wrA = 3'(c - CLR0);
        expMem[c - CLR0] = 8'h00;
      end else if (ic >= RUN0 && ic < DRN0 && ((ic - RUN0) % (N + 1)) != 0) begin
        wa = ((ic - RUN0) % (N + 1)) - 1;
        if (!rnd) uj = aw[8*wa +: 8];
        wrE = 1'b1; wrA = 3'(wa); wrD = uj;
        expMem[wa] = uj;
      end else if (c == CAR) begin
        carry = carryBit;
        wrE = 1'b1; wrA = 3'(N); wrD = {7'b0, carryBit};
        expMem[N] = {7'b0, carryBit};
      end
      start = (c == startAt);
      if (c == abortAt) rst = 1'b1;
      #1;
      if (c == SUB0) begin
        aVal = '0; mVal = '0;
        for (int n = 0; n <= N; n++) aVal = aVal | (64'(expMem[n]) << (8 * n));
        for (int n = 0; n < N; n++)  mVal = mVal | (64'(mMem[n]) << (8 * n));
        dVal   = aVal - mVal;
        expSel = (aVal >= mVal);
      end
      checkOutput("busy", 64'(busy), 64'(c >= CLR0 && c < DONE));
      checkOutput("done", 64'(done), 64'(c == DONE));
      checkOutput("ctlCarryClr", 64'(ctlCarryClr), 64'(inRun && idx == 0));
      checkOutput("ctlCarryEna", 64'(ctlCarryEna), 64'(inRun && (idx % (N + 1)) == N));
      checkOutput("ctlCarrySel", 64'(ctlCarrySel), 64'(inRun && (idx % (N + 1)) == N));
      checkOutput("ctlCPreClr", 64'(ctlCPreClr), 64'(inRun && (idx % (N + 1)) == 0));
      checkOutput("ctlQEna", 64'(ctlQEna), 64'(inRun && (idx % (N + 1)) == 0));
      if (inRun) begin
        checkOutput("j", 64'(j), 64'(idx % (N + 1)));
        checkOutput("i", 64'(i), 64'(idx / (N + 1)));
        checkOutput("rdAddrRun", 64'(rdAddr), 64'(idx % (N + 1)));
      end
      checkOutput("wrEna", 64'(wrEna), 64'(wrE));
      if (wrE) begin
        checkOutput("wrAddr", 64'(wrAddr), 64'(wrA));
        checkOutput("wrData", 64'(wrData), 64'(wrD));
      end
      checkOutput("resValid", 64'(resValid), 64'(inSub));
      if (inSub) begin
        checkOutput("rdAddrSub", 64'(rdAddr), 64'(k));
        checkOutput("resA", 64'(resA), 64'(expMem[k]));
        checkOutput("resD", 64'(resD), 64'(dVal[8*k +: 8]));
        checkOutput("resLast", 64'(resLast), 64'(k == N));
        if (k == 0) d0Out = resD;
      end
      checkOutput("resSel", 64'(resSel), 64'((c >= DONE) ? expSel : 1'b0));
      selOut = resSel;
      if (c == abortAt) begin
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int p = 1; p <= 6; p++) begin
          curCycle = c + p;
          checkIdle("postReset");
          @(posedge clk);
          #1;
        end
        break;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] aw;
    logic [31:0] mw;
    logic        cy;
    logic        rnd;
    logic        useExp;
    logic        expSel;
    logic [7:0]  expD0;
  } vec_t;

  vec_t vecs [6];

  // Test sequence: reset state, table of multiplies, reset mid-RUN, start during RUN.
  initial begin
    logic       sel;
    logic [7:0] d0;
    vecs[0] = '{aw: 32'h00000005, mw: 32'h00000007, cy: 1'b0, rnd: 1'b0, useExp: 1'b1, expSel: 1'b0, expD0: 8'hFE};
    vecs[1] = '{aw: 32'h00000009, mw: 32'h00000007, cy: 1'b0, rnd: 1'b0, useExp: 1'b1, expSel: 1'b1, expD0: 8'h02};
    vecs[2] = '{aw: 32'h00000000, mw: 32'hFFFFFFFF, cy: 1'b1, rnd: 1'b0, useExp: 1'b1, expSel: 1'b1, expD0: 8'h01};
    vecs[3] = '{aw: 32'h78563412, mw: 32'h78563412, cy: 1'b0, rnd: 1'b0, useExp: 1'b1, expSel: 1'b1, expD0: 8'h00};
    vecs[4] = '{aw: $urandom, mw: $urandom, cy: 1'b1, rnd: 1'b1, useExp: 1'b0, expSel: 1'b0, expD0: 8'h00};
    vecs[5] = '{aw: $urandom, mw: $urandom, cy: 1'b0, rnd: 1'b1, useExp: 1'b0, expSel: 1'b0, expD0: 8'h00};
    for (int n = 0; n <= N; n++) ram[n] = 8'h00;
    for (int n = 0; n < N; n++) mMem[n] = 8'h00;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    curCycle = 0;
    checkIdle("reset");

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].aw, vecs[v].mw, vecs[v].cy, vecs[v].rnd, -1, -1, sel, d0);
      if (vecs[v].useExp) begin
        checkOutput($sformatf("vec%0d_resSel", v), 64'(sel), 64'(vecs[v].expSel));
        checkOutput($sformatf("vec%0d_resD0", v), 64'(d0), 64'(vecs[v].expD0));
      end
    end

    applyStimulus(32'h11223344, 32'h01020304, 1'b1, 1'b0, 15, -1, sel, d0);
    applyStimulus(32'h00000009, 32'h00000007, 1'b0, 1'b0, -1, -1, sel, d0);
    checkOutput("afterAbort_resSel", 64'(sel), 64'd1);

    applyStimulus(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0, -1, 12, sel, d0);
    checkOutput("startInRun_resSel", 64'(sel), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout cycle=%0d actual=running required=finished", curCycle);
    $fatal(1, "[TB] timeout");
  end

endmodule
